// File: rtl/params_pkg.sv
// Shared memory-side types and arbiter enums for the L1-to-memory path.
package params_pkg;

  localparam int PADDR_W = 32;
  localparam int LINE_W  = 128;

  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [LINE_W-1:0]  cacheline_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE      = 2'd0;
  localparam arb_state_t ISSUE     = 2'd1;
  localparam arb_state_t WAIT_RESP = 2'd2;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner select: lowest set index (fixed) or first set index at/after rr_ptr (round-robin).
// Zero latency; emits no grant when no request is set.
module rr_picker
  import params_pkg::*;
#(
  parameter int        NUM_REQ  = 2,
  parameter arb_mode_e ARB_MODE = ARB_FIXED,
  parameter int        ID_W     = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               gnt_vld_o
);

  logic [2*NUM_REQ-1:0] dbl_req;
  int unsigned          base;
  logic                 found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    base     = (ARB_MODE == ARB_RR) ? 32'(rr_ptr_i) : 32'd0;
    // Rotating the doubled vector puts rr_ptr at bit 0, so the first set bit is the winner.
    dbl_req  = {req_i, req_i} >> base;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && dbl_req[k]) begin
        found    = 1'b1;
        gnt_id_o = ID_W'((base + 32'(k)) % 32'(NUM_REQ));
      end
    end
    if (found) begin
      gnt_o[gnt_id_o] = 1'b1;
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Shares one cacheline memory port among NUM_REQ requesters, one transaction in flight, optional timeout.
// Grant one cycle after request, earliest response one cycle after grant; requesters hold req_valid until req_gnt.
module mem_arbiter_rr
  import params_pkg::*;
#(
  parameter int        NUM_REQ        = 2,
  parameter arb_mode_e ARB_MODE       = ARB_FIXED,
  parameter int        TIMEOUT_CYCLES = 0,
  parameter int        TO_W           = clog2_min1(TIMEOUT_CYCLES + 1),
  parameter int        ID_W           = clog2_min1(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  paddr_t     [NUM_REQ-1:0]   req_addr,
  input  cacheline_t [NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         req_gnt,
  output cacheline_t                 req_rdata,
  output logic [NUM_REQ-1:0]         req_rvalid,
  output logic [NUM_REQ-1:0]         req_err,
  output logic                       mem_req,
  output logic                       mem_we,
  output paddr_t                     mem_addr,
  output cacheline_t                 mem_wdata,
  input  cacheline_t                 mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       busy,
  output logic [ID_W-1:0]            owner_id
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             cmd_we_q, cmd_we_d;
  paddr_t           cmd_addr_q, cmd_addr_d;
  cacheline_t       cmd_wdata_q, cmd_wdata_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;
  logic               timeout_hit;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE),
    .ID_W     (ID_W)
  ) u_picker (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_id_o  (pick_id),
    .gnt_vld_o (pick_vld)
  );

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    to_cnt_d    = to_cnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    req_gnt     = '0;
    req_rvalid  = '0;
    req_err     = '0;
    mem_req     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = ISSUE;
          owner_d     = pick_id;
          rr_ptr_d    = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
          cmd_we_d    = 1'b0;
          cmd_addr_d  = '0;
          cmd_wdata_d = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
              cmd_we_d    = req_we[i];
              cmd_addr_d  = req_addr[i];
              cmd_wdata_d = req_wdata[i];
            end
          end
        end
      end

      ISSUE: begin
        req_gnt[owner_q] = 1'b1;
        mem_req          = 1'b1;
        to_cnt_d         = '0;
        state_d          = WAIT_RESP;
      end

      WAIT_RESP: begin
        // A response arriving on the expiry cycle still completes normally.
        if (mem_rvalid) begin
          req_rvalid[owner_q] = 1'b1;
          state_d             = IDLE;
        end else if (timeout_hit) begin
          req_err[owner_q] = 1'b1;
          state_d          = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      to_cnt_q    <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= (ARB_MODE == ARB_RR) ? rr_ptr_d : '0;
      to_cnt_q    <= to_cnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign mem_we    = cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign req_rdata = mem_rdata;
  assign busy      = (state_q != IDLE);
  assign owner_id  = owner_q;

endmodule
